// File: rtl/x1dn_pkg.sv
// ---------------------------------------------------------------------------
// x1dn_pkg: shared frame geometry and deserializer state encoding.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package x1dn_pkg;

  localparam int FRAME_BYTES = 4;
  localparam int X_WIDTH     = 27;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B1   = 3'd1,
    B2   = 3'd2,
    B3   = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/x1dn_in_deser.sv
// ---------------------------------------------------------------------------
// x1dn_in_deser: assembles 4-byte frames into the 27-bit x1dn input vector.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module x1dn_in_deser
  import x1dn_pkg::*;
#(
  parameter int FRAME_CNT_W = 16,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_sof,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [X_WIDTH-1:0]     x_vec,
  output logic                   x_valid,
  input  logic                   x_ready,
  output logic                   frame_err,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  localparam int ASM_W = (FRAME_BYTES - 1) * 8;

  state_e               state_q, state_d;
  logic [X_WIDTH-1:0]   asm_q, asm_d;
  logic [X_WIDTH-1:0]   xvec_q, xvec_d;
  logic                 xval_q, xval_d;
  logic                 err_q, err_d;
  logic [FRAME_CNT_W-1:0] fcnt_q;
  logic [ERR_CNT_W-1:0]   ecnt_q;
  logic                 accept;
  logic                 drain;

  assign in_ready = ~rst & (state_q != DONE);
  assign accept   = in_valid & in_ready;
  assign drain    = xval_q & x_ready;

  always_comb begin
    state_d = state_q;
    asm_d   = asm_q;
    xvec_d  = xvec_q;
    xval_d  = xval_q & ~drain;
    err_d   = 1'b0;
    if (state_q == DONE) begin
      // Parked frame moves into the holding register as soon as it frees up.
      if (drain) begin
        xvec_d  = asm_q;
        xval_d  = 1'b1;
        state_d = IDLE;
      end
    end else if (accept) begin
      if (in_sof) begin
        err_d       = (state_q != IDLE);
        asm_d[7:0]  = in_data;
        state_d     = B1;
      end else begin
        case (state_q)
          IDLE: err_d = 1'b1;
          B1: begin
            asm_d[15:8] = in_data;
            state_d     = B2;
          end
          B2: begin
            asm_d[23:16] = in_data;
            state_d      = B3;
          end
          B3: begin
            if (in_data[7:3] != 5'd0) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              asm_d[X_WIDTH-1:ASM_W] = in_data[2:0];
              if (!xval_q || drain) begin
                xvec_d  = {in_data[2:0], asm_q[ASM_W-1:0]};
                xval_d  = 1'b1;
                state_d = IDLE;
              end else begin
                state_d = DONE;
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      asm_q   <= '0;
      xvec_q  <= '0;
      xval_q  <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      asm_q   <= asm_d;
      xvec_q  <= xvec_d;
      xval_q  <= xval_d;
      err_q   <= err_d;
      if (drain) begin
        fcnt_q <= fcnt_q + FRAME_CNT_W'(1);
      end
      if (err_q && !(&ecnt_q)) begin
        ecnt_q <= ecnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign x_vec     = xvec_q;
  assign x_valid   = xval_q;
  assign frame_err = err_q;
  assign frame_cnt = fcnt_q;
  assign err_cnt   = ecnt_q;

endmodule

`default_nettype wire

// File: tb/tb_x1dn_in_deser.sv
// ---------------------------------------------------------------------------
// tb_x1dn_in_deser: directed and random checks against a frame-level model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_x1dn_in_deser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_sof;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] x_vec;
  logic        x_valid;
  logic        x_ready;
  logic        frame_err;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  x1dn_in_deser #(.FRAME_CNT_W(16), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sof(in_sof),
    .in_valid(in_valid), .in_ready(in_ready), .x_vec(x_vec),
    .x_valid(x_valid), .x_ready(x_ready), .frame_err(frame_err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  // Model: delivered frames awaiting consumption (capacity 2) and bytes of
  // the frame currently being gathered.
  logic [26:0] mq[$];
  logic [7:0]  cur[$];
  logic        err_m;
  logic [15:0] fcnt_m;
  logic [7:0]  ecnt_m;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic s,
                      input logic [7:0] d, input logic xr);
    logic acc, drn;
    rst = r; in_valid = v; in_sof = s; in_data = d; x_ready = xr;
    @(posedge clk);
    if (r) begin
      mq.delete(); cur.delete();
      err_m = 1'b0; fcnt_m = '0; ecnt_m = '0;
    end else begin
      acc = v && (mq.size() < 2);
      drn = xr && (mq.size() > 0);
      if (err_m && ecnt_m != 8'hFF) ecnt_m++;
      err_m = 1'b0;
      if (drn) begin
        void'(mq.pop_front());
        fcnt_m++;
      end
      if (acc) begin
        if (s) begin
          err_m = (cur.size() != 0);
          cur.delete();
          cur.push_back(d);
        end else if (cur.size() == 0) begin
          err_m = 1'b1;
        end else if (cur.size() < 3) begin
          cur.push_back(d);
        end else begin
          if (d > 8'h07) err_m = 1'b1;
          else mq.push_back({d[2:0], cur[2], cur[1], cur[0]});
          cur.delete();
        end
      end
    end
    @(negedge clk);
    chk("in_ready", {31'b0, in_ready}, {31'b0, (!r && mq.size() < 2)});
    chk("x_valid", {31'b0, x_valid}, {31'b0, (mq.size() != 0)});
    chk("frame_err", {31'b0, frame_err}, {31'b0, err_m});
    chk("frame_cnt", {16'b0, frame_cnt}, {16'b0, fcnt_m});
    chk("err_cnt", {24'b0, err_cnt}, {24'b0, ecnt_m});
    if (mq.size() != 0) chk("x_vec", {5'b0, x_vec}, {5'b0, mq[0]});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; x_ready = 1'b0;
    err_m = 1'b0; fcnt_m = '0; ecnt_m = '0;

    step(1, 0, 0, 8'h00, 1);
    step(1, 1, 1, 8'h5A, 1);
    chk("rst_x_vec", {5'b0, x_vec}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
    step(0, 0, 0, 8'h00, 1);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'h1);

    // Back-to-back frame with the sink always ready.
    step(0, 1, 1, 8'h55, 1);
    step(0, 1, 0, 8'hAA, 1);
    step(0, 1, 0, 8'h0F, 1);
    step(0, 1, 0, 8'h05, 1);
    chk("b2b_vec", {5'b0, x_vec}, 32'h050FAA55);
    step(0, 0, 0, 8'h00, 1);
    chk("b2b_cnt", {16'b0, frame_cnt}, 32'h1);

    // Two frames against a stalled sink.
    step(0, 1, 1, 8'h11, 0);
    step(0, 1, 0, 8'h22, 0);
    step(0, 1, 0, 8'h33, 0);
    step(0, 1, 0, 8'h01, 0);
    step(0, 1, 1, 8'h44, 0);
    step(0, 1, 0, 8'h55, 0);
    step(0, 1, 0, 8'h66, 0);
    step(0, 1, 0, 8'h02, 0);
    chk("stall_in_ready", {31'b0, in_ready}, 32'h0);
    chk("stall_vec", {5'b0, x_vec}, 32'h01332211);
    step(0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 1);
    chk("stall_second_vec", {5'b0, x_vec}, 32'h02665544);
    step(0, 0, 0, 8'h00, 1);
    chk("stall_cnt", {16'b0, frame_cnt}, 32'h3);

    // Start-of-frame arriving on byte 2 restarts assembly.
    step(0, 1, 1, 8'h10, 1);
    step(0, 1, 0, 8'h20, 1);
    step(0, 1, 1, 8'h30, 1);
    chk("resync_err", {31'b0, frame_err}, 32'h1);
    step(0, 1, 0, 8'h40, 1);
    chk("resync_err_cnt", {24'b0, err_cnt}, 32'h1);
    step(0, 1, 0, 8'h50, 1);
    step(0, 1, 0, 8'h03, 1);
    chk("resync_vec", {5'b0, x_vec}, 32'h03504030);

    // Illegal upper bits in byte 3.
    step(0, 1, 1, 8'h01, 1);
    step(0, 1, 0, 8'h02, 1);
    step(0, 1, 0, 8'h03, 1);
    step(0, 1, 0, 8'h08, 1);
    chk("bad_b3_err", {31'b0, frame_err}, 32'h1);
    chk("bad_b3_valid", {31'b0, x_valid}, 32'h0);
    step(0, 1, 0, 8'h77, 1);
    chk("bad_b3_idle", {31'b0, frame_err}, 32'h1);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) step(0, 1, 0, 8'(i), 1);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 1);
    chk("err_sat", {24'b0, err_cnt}, 32'hFF);

    // Reset while a frame is held and another is half-assembled.
    step(0, 1, 1, 8'h0A, 0);
    step(0, 1, 0, 8'h0B, 0);
    step(0, 1, 0, 8'h0C, 0);
    step(0, 1, 0, 8'h00, 0);
    step(0, 1, 1, 8'h0D, 0);
    step(0, 1, 0, 8'h0E, 0);
    chk("pre_rst_valid", {31'b0, x_valid}, 32'h1);
    step(1, 0, 0, 8'h00, 0);
    chk("mid_rst_valid", {31'b0, x_valid}, 32'h0);
    chk("mid_rst_fcnt", {16'b0, frame_cnt}, 32'h0);
    chk("mid_rst_ecnt", {24'b0, err_cnt}, 32'h0);
    step(0, 0, 0, 8'h00, 1);
    step(0, 1, 1, 8'h21, 1);
    step(0, 1, 0, 8'h22, 1);
    step(0, 1, 0, 8'h23, 1);
    step(0, 1, 0, 8'h04, 1);
    chk("post_rst_vec", {5'b0, x_vec}, 32'h04232221);

    // Random traffic, mostly well-formed, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 7));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0), d, ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
